// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: forwarding selects, load/branch stalls, divide stall FSM
module hazard_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       branch_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic       regwrite_e,
  input  logic       memtoreg_e,
  input  logic       div_e,
  input  logic [4:0] writereg_m,
  input  logic       regwrite_m,
  input  logic       memtoreg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_w,
  output logic       forwardad,
  output logic       forwardbd,
  output logic [1:0] forwardae,
  output logic [1:0] forwardbe,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_e,
  output logic       div_start,
  output logic       div_busy,
  output logic       div_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Last BUSY count value; BUSY spans counts 0..DIV_CYCLES-1.
  localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

  logic [1:0] state;
  logic [4:0] cnt;
  logic       lwstall;
  logic       branchstall;
  logic       divstall;

  // EX operand forwarding: the younger MEM result wins over WB; r0 never forwards.
  always_comb begin
    forwardae = 2'b00;
    if (rs_e != 5'd0 && regwrite_m && rs_e == writereg_m)
      forwardae = 2'b10;
    else if (rs_e != 5'd0 && regwrite_w && rs_e == writereg_w)
      forwardae = 2'b01;

    forwardbe = 2'b00;
    if (rt_e != 5'd0 && regwrite_m && rt_e == writereg_m)
      forwardbe = 2'b10;
    else if (rt_e != 5'd0 && regwrite_w && rt_e == writereg_w)
      forwardbe = 2'b01;
  end

  assign forwardad = (rs_d != 5'd0) & regwrite_m & (rs_d == writereg_m);
  assign forwardbd = (rt_d != 5'd0) & regwrite_m & (rt_d == writereg_m);

  assign lwstall = memtoreg_e & (rt_e != 5'd0) & ((rt_e == rs_d) | (rt_e == rt_d));

  // A branch in ID needs its operands now: wait on an EX writer or a MEM load.
  assign branchstall = branch_d &
    ((regwrite_e & (writereg_e != 5'd0) & ((writereg_e == rs_d) | (writereg_e == rt_d))) |
     (memtoreg_m & (writereg_m != 5'd0) & ((writereg_m == rs_d) | (writereg_m == rt_d))));

  // Status is masked during reset because state only clears at the next edge.
  assign div_start = ~rst & (state == IDLE) & div_e;
  assign div_busy  = ~rst & (state == BUSY);
  assign div_done  = ~rst & (state == DONE);
  assign divstall  = div_start | div_busy;

  // Stall/flush arbitration: the divide freezes everything and must not flush its own EX slot.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    if (!rst) begin
      if (divstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
      end else begin
        stall_f = lwstall | branchstall;
        stall_d = lwstall | branchstall;
        flush_e = lwstall | branchstall;
      end
    end
  end

  // Divide sequencer: IDLE -> BUSY for DIV_CYCLES cycles -> DONE for one cycle -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (div_e) begin
            state <= BUSY;
            cnt   <= 5'd0;
          end
        end
        BUSY: begin
          if (cnt == CNT_LAST)
            state <= DONE;
          else
            cnt <= cnt + 5'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

  localparam int DC = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       branch_d, regwrite_e, memtoreg_e, div_e;
  logic       regwrite_m, memtoreg_m, regwrite_w;
  logic       forwardad, forwardbd, stall_f, stall_d, stall_e, flush_e;
  logic [1:0] forwardae, forwardbe;
  logic       div_start, div_busy, div_done;

  int n_cmp = 0;
  int n_fail = 0;

  hazard_unit #(.DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
    .rs_e(rs_e), .rt_e(rt_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .div_e(div_e),
    .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .writereg_w(writereg_w), .regwrite_w(regwrite_w),
    .forwardad(forwardad), .forwardbd(forwardbd),
    .forwardae(forwardae), .forwardbe(forwardbe),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .flush_e(flush_e),
    .div_start(div_start), .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] name;
    logic [4:0]  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic        branch_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
    logic [5:0]  fwd;    // {forwardae, forwardbe, forwardad, forwardbd}
    logic        stall;  // stall_f = stall_d = flush_e, stall_e = 0
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ctl();
    return int'({stall_f, stall_d, stall_e, flush_e, div_start, div_busy, div_done});
  endfunction

  function automatic int fwd();
    return int'({forwardae, forwardbe, forwardad, forwardbd});
  endfunction

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; writereg_e = 0; writereg_m = 0; writereg_w = 0;
    branch_d = 0; regwrite_e = 0; memtoreg_e = 0; div_e = 0;
    regwrite_m = 0; memtoreg_m = 0; regwrite_w = 0;
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Reference forwarding select from the priority rule.
  function automatic logic [1:0] ref_fwd_e(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (regwrite_m && src == writereg_m) return 2'b10;
    if (regwrite_w && src == writereg_w) return 2'b01;
    return 2'b00;
  endfunction

  int phase;  // 0 = no divide, 1..DC = BUSY cycle number, DC+1 = DONE cycle

  initial begin
    vecs[0]  = '{default: '0, name: "fwd_mem", rs_e: 5, writereg_m: 5, regwrite_m: 1, writereg_w: 5, regwrite_w: 1, fwd: 6'b10_00_0_0};
    vecs[1]  = '{default: '0, name: "fwd_wb", rs_e: 5, writereg_m: 5, regwrite_m: 0, writereg_w: 5, regwrite_w: 1, fwd: 6'b01_00_0_0};
    vecs[2]  = '{default: '0, name: "fwd_r0", rs_e: 0, writereg_m: 5, regwrite_m: 1, writereg_w: 5, regwrite_w: 1, fwd: 6'b00_00_0_0};
    vecs[3]  = '{default: '0, name: "lw_stall", memtoreg_e: 1, rt_e: 8, rs_d: 8, stall: 1};
    vecs[4]  = '{default: '0, name: "lw_r0", memtoreg_e: 1, rt_e: 0, rs_d: 0};
    vecs[5]  = '{default: '0, name: "br_ex", branch_d: 1, rs_d: 3, regwrite_e: 1, writereg_e: 3, stall: 1};
    vecs[6]  = '{default: '0, name: "br_mem_alu", branch_d: 1, rs_d: 3, regwrite_m: 1, writereg_m: 3, fwd: 6'b00_00_1_0};
    vecs[7]  = '{default: '0, name: "br_mem_ld", branch_d: 1, rs_d: 3, regwrite_m: 1, memtoreg_m: 1, writereg_m: 3, fwd: 6'b00_00_1_0, stall: 1};
    vecs[8]  = '{default: '0, name: "fwd_b", rt_e: 7, rt_d: 7, regwrite_m: 1, writereg_m: 7, fwd: 6'b00_10_0_1};
    vecs[9]  = '{default: '0, name: "lw_rt", memtoreg_e: 1, rt_e: 4, rt_d: 4, stall: 1};
    vecs[10] = '{default: '0, name: "br_r0", branch_d: 1, regwrite_e: 1, writereg_e: 0};

    clear_inputs();
    rst = 1;
    next_cycle();
    // Reset: control outputs forced low even with divide/load requests; forwarding still live.
    div_e = 1; memtoreg_e = 1; rt_e = 8; rs_d = 8;
    rs_e = 5; writereg_m = 5; regwrite_m = 1;
    settle();
    chk("reset_ctl", ctl(), 0);
    chk("reset_fwd", int'(forwardae), 2);
    next_cycle();
    rst = 0;
    clear_inputs();

    // Combinational vector table (FSM idle, no divide).
    foreach (vecs[i]) begin
      rs_d = vecs[i].rs_d; rt_d = vecs[i].rt_d; rs_e = vecs[i].rs_e; rt_e = vecs[i].rt_e;
      writereg_e = vecs[i].writereg_e; writereg_m = vecs[i].writereg_m; writereg_w = vecs[i].writereg_w;
      branch_d = vecs[i].branch_d; regwrite_e = vecs[i].regwrite_e; memtoreg_e = vecs[i].memtoreg_e;
      regwrite_m = vecs[i].regwrite_m; memtoreg_m = vecs[i].memtoreg_m; regwrite_w = vecs[i].regwrite_w;
      settle();
      chk($sformatf("%0s_fwd", vecs[i].name), fwd(), int'(vecs[i].fwd));
      chk($sformatf("%0s_ctl", vecs[i].name), ctl(),
          vecs[i].stall ? int'(7'b1101_000) : 0);
      next_cycle();
    end
    clear_inputs();

    // div_e held high: start, DC busy cycles, done, then idle (restarts as div_e is still high).
    div_e = 1;
    for (int c = 0; c <= DC + 2; c++) begin
      int e;
      settle();
      if (c == 0 || c == DC + 2) e = 7'b1110_100;
      else if (c <= DC)          e = 7'b1110_010;
      else                       e = 7'b0000_001;
      chk($sformatf("div_held_c%0d", c), ctl(), e);
      if (c == DC + 2) rst = 1;
      next_cycle();
    end
    rst = 0;
    clear_inputs();

    // Divide overlapping a load-use hazard: no flush while dividing, load stall after DONE.
    memtoreg_e = 1; rt_e = 8; rs_d = 8;
    for (int c = 0; c <= DC + 2; c++) begin
      int e;
      div_e = (c == 0);
      settle();
      if (c == 0)       e = 7'b1110_100;
      else if (c <= DC) e = 7'b1110_010;
      else if (c == DC + 1) e = 7'b1101_001;
      else              e = 7'b1101_000;
      chk($sformatf("div_lw_c%0d", c), ctl(), e);
      next_cycle();
    end

    // Reset mid-BUSY (count 10) aborts; a new divide gets the full BUSY length.
    for (int c = 0; c <= DC + 14; c++) begin
      int e;
      div_e = (c == 0 || c == 12);
      rst   = (c == 11);
      settle();
      if (c == 0 || c == 12)     e = 7'b1110_100;
      else if (c <= 10)          e = 7'b1110_010;
      else if (c == 11)          e = 0;
      else if (c <= DC + 12)     e = 7'b1110_010;
      else if (c == DC + 13)     e = 7'b1101_001;
      else                       e = 7'b1101_000;
      chk($sformatf("div_rst_c%0d", c), ctl(), e);
      next_cycle();
    end
    rst = 0;
    clear_inputs();
    next_cycle();

    // Randomized run against a cycle-phase reference model.
    phase = 0;
    for (int n = 0; n < 3000; n++) begin
      logic lw, br, ds, st;
      int   e;
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      writereg_e = 5'($urandom_range(0, 3)); writereg_m = 5'($urandom_range(0, 3));
      writereg_w = 5'($urandom_range(0, 3));
      branch_d = 1'($urandom); regwrite_e = 1'($urandom); memtoreg_e = 1'($urandom);
      regwrite_m = 1'($urandom); memtoreg_m = 1'($urandom); regwrite_w = 1'($urandom);
      div_e = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      settle();
      lw = memtoreg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
      br = branch_d && ((regwrite_e && writereg_e != 0 && (writereg_e == rs_d || writereg_e == rt_d)) ||
                        (memtoreg_m && writereg_m != 0 && (writereg_m == rs_d || writereg_m == rt_d)));
      ds = (phase == 0 && div_e) || (phase >= 1 && phase <= DC);
      st = lw || br;
      if (rst) e = 0;
      else e = int'({ds, ds, ds, 1'b0, phase == 0 && div_e, phase >= 1 && phase <= DC, phase == DC + 1})
             | (ds ? 0 : int'({st, st, 1'b0, st, 3'b000}));
      chk($sformatf("rnd%0d_ctl", n), ctl(), e);
      chk($sformatf("rnd%0d_fwd", n), fwd(),
          int'({ref_fwd_e(rs_e), ref_fwd_e(rt_e),
                rs_d != 0 && regwrite_m && rs_d == writereg_m,
                rt_d != 0 && regwrite_m && rt_d == writereg_m}));
      if (rst)              phase = 0;
      else if (phase == 0)  phase = div_e ? 1 : 0;
      else if (phase <= DC) phase = phase + 1;
      else                  phase = 0;
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: DIV_CYCLES, 32, number of BUSY cycles a divide occupies the EX stage.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rs_d, rt_d  in  5 each  source register numbers of the ID-stage instruction.
REQ-005 branch_d  in  1  ID instruction is a branch that compares registers in ID.
REQ-006 rs_e, rt_e, writereg_e  in  5 each  EX source registers and destination register.
REQ-007 regwrite_e, memtoreg_e, div_e  in  1 each  EX writes a register / is a load / is div or divu.
REQ-008 writereg_m  in  5; regwrite_m, memtoreg_m  in  1 each  MEM destination, write enable, load flag.
REQ-009 writereg_w  in  5; regwrite_w  in  1  WB destination and write enable.
REQ-010 forwardad, forwardbd  out  1 each  ID branch-compare operand select: 1 = MEM ALU result.
REQ-011 forwardae, forwardbe  out  2 each  EX operand select: 00 = ID/EX register value, 01 = WB result, 10 = MEM ALU result; 11 never driven.
REQ-012 stall_f, stall_d, stall_e  out  1 each  hold PC, IF/ID, and ID/EX registers.
REQ-013 flush_e  out  1  clear the ID/EX register (insert bubble).
REQ-014 div_start, div_busy, div_done  out  1 each  divider control pulses and status.

Function
REQ-015 forwardae: 10 when rs_e!=0, regwrite_m, and rs_e==writereg_m; else 01 when rs_e!=0, regwrite_w, and rs_e==writereg_w; else 00. MEM match takes priority over WB match.
REQ-016 forwardbe: same rule as forwardae, using rt_e.
REQ-017 forwardad = rs_d!=0 & regwrite_m & rs_d==writereg_m; forwardbd: same rule using rt_d.
REQ-018 lwstall = memtoreg_e & (rt_e!=0) & (rt_e==rs_d | rt_e==rt_d).
REQ-019 branchstall = branch_d & ((regwrite_e & writereg_e!=0 & (writereg_e==rs_d | writereg_e==rt_d)) | (memtoreg_m & writereg_m!=0 & (writereg_m==rs_d | writereg_m==rt_d))).
REQ-020 Divide FSM states: IDLE, BUSY, DONE; 5-bit counter cnt.
REQ-021 Transition IDLE->BUSY when div_e=1; cnt loads 0; otherwise remain in IDLE.
REQ-022 In BUSY, cnt increments each cycle; transition BUSY->DONE on the cycle cnt==DIV_CYCLES-1.
REQ-023 Transition DONE->IDLE unconditionally after one cycle; div_e is ignored in DONE, so back-to-back divides restart only from IDLE.
REQ-024 div_start = (state==IDLE) & div_e (one-cycle pulse); div_busy = (state==BUSY); div_done = (state==DONE).
REQ-025 divstall = div_start | div_busy. A divide holds EX for DIV_CYCLES+2 cycles, of which DIV_CYCLES+1 are stalled.
REQ-026 When divstall=1: stall_f = stall_d = stall_e = 1 and flush_e = 0. Divide stall overrides lwstall and branchstall.
REQ-027 When divstall=0: stall_f = stall_d = lwstall | branchstall; flush_e = lwstall | branchstall; stall_e = 0.
REQ-028 All outputs are combinational from inputs and current state; no extra output latency.
REQ-029 Counter width is sufficient for DIV_CYCLES <= 32; cnt never wraps within BUSY.

Reset
REQ-030 When rst=1 at a rising edge: state<=IDLE and cnt<=0.
REQ-031 While rst=1: stall_f, stall_d, stall_e, flush_e, div_start, div_busy, and div_done are all 0. Forward selects continue to follow REQ-015..017.
REQ-032 rst asserted during BUSY or DONE aborts the divide; the first cycle after rst deasserts is IDLE.

Verification
REQ-033 Stimulus: rs_e=5, writereg_m=5, regwrite_m=1, writereg_w=5, regwrite_w=1 -> forwardae=10. Same with regwrite_m=0 -> forwardae=01. Same with rs_e=0 -> forwardae=00.
REQ-034 Stimulus: memtoreg_e=1, rt_e=8, rs_d=8 -> stall_f=stall_d=flush_e=1, stall_e=0. Same with rt_e=0 -> all four outputs 0.
REQ-035 Stimulus: branch_d=1, rs_d=3, regwrite_e=1, writereg_e=3 -> stall_f=stall_d=flush_e=1. Next cycle with the writer now in MEM as a non-load -> no stall, forwardad=1.
REQ-036 Stimulus: div_e held at 1 from cycle 0 -> div_start=1 in cycle 0; div_busy=1 in cycles 1..32; div_done=1 in cycle 33 with stall_e=0; IDLE in cycle 34.
REQ-037 Stimulus: divide in progress together with lwstall conditions -> flush_e=0 and all stalls=1 throughout; lwstall takes effect after DONE.
REQ-038 Stimulus: rst pulsed in BUSY at cnt=10 -> all stall outputs 0 during rst; a subsequent div_e=1 restarts with a full 32-cycle BUSY.
